shift_register_sequencer: RTL

Controller that sequences an internal WIDTH-bit shift register: accepts a parallel word over a valid/ready load handshake, then shifts it out one bit per accepted serial beat over a valid/ready serial handshake. Direction is selectable per word. Sits between parallel data producers (PIPO staging registers) and serial consumers in the shift-register family of blocks. Reports completion with a one-cycle done pulse.

---
 rtl/shift_reg_pkg.sv | 12 +
 rtl/bidir_shift_reg.sv | 29 ++
 rtl/shift_register_sequencer.sv | 94 +++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared constants for the shift-register controller family: FSM encoding
// and serial direction codes.
package shift_reg_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/bidir_shift_reg.sv
// WIDTH-bit register with parallel load, left/right shift with a fill bit,
// and hold. Falling-edge clocked, asynchronous active-high reset.
module bidir_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Load_En,
    input  logic             Shift_Left_En,
    input  logic             Shift_Right_En,
    input  logic             Fill_Bit,
    input  logic [WIDTH-1:0] Data_In,
    output logic [WIDTH-1:0] Data_Out
);

    // Load wins over shift; left and right are never requested together.
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            Data_Out <= '0;
        end else if (Load_En) begin
            Data_Out <= Data_In;
        end else if (Shift_Left_En) begin
            Data_Out <= {Data_Out[WIDTH-2:0], Fill_Bit};
        end else if (Shift_Right_En) begin
            Data_Out <= {Fill_Bit, Data_Out[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_register_sequencer.sv
// Loads a parallel word over a valid/ready handshake and serialises it one
// bit per accepted beat, MSB- or LSB-first, with a one-cycle done pulse.
module shift_register_sequencer
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Load_Valid_In,
    output logic             Load_Ready_Out,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    input  logic             Shift_Dir_In,
    output logic             Serial_Data_Out,
    output logic             Serial_Valid_Out,
    input  logic             Serial_Ready_In,
    output logic             Busy_Out,
    output logic             Done_Out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] shreg_q;
    logic             load_fire;
    logic             beat_fire;

    assign load_fire = Load_Valid_In && (state_q == IDLE);
    assign beat_fire = Serial_Ready_In && (state_q == SHIFT);

    bidir_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .Clk_In         (Clk_In),
        .Reset_In       (Reset_In),
        .Load_En        (load_fire),
        .Shift_Left_En  (beat_fire && (dir_q == DIR_MSB_FIRST)),
        .Shift_Right_En (beat_fire && (dir_q == DIR_LSB_FIRST)),
        .Fill_Bit       (1'b0),
        .Data_In        (Parallel_Data_In),
        .Data_Out       (shreg_q)
    );

    // The last accepted beat moves to DONE instead of wrapping the counter.
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_fire) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        dir_q   <= Shift_Dir_In;
                    end
                end
                SHIFT: begin
                    if (Serial_Ready_In) begin
                        if (cnt_q == LAST_BIT) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Load_Ready_Out   = (state_q == IDLE);
    assign Serial_Valid_Out = (state_q == SHIFT);
    assign Busy_Out         = (state_q == SHIFT) || (state_q == DONE);
    assign Done_Out         = (state_q == DONE);

    // Data is forced low whenever no bit is being offered.
    always_comb begin
        Serial_Data_Out = 1'b0;
        if (state_q == SHIFT) begin
            Serial_Data_Out = (dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
        end
    end

endmodule
